alu_cmd_sequencer: RTL and testbench

- Sequential initiator for the team's combinational 8-bit ALU (A, B, 4-bit select in; 16-bit result and carry out).
- Accepts tagged operation commands on a valid/ready interface and buffers them in a FIFO.
- Drives each command onto the ALU, captures the result, and returns it in order on a valid/ready response interface.
- Sits between a control master (CPU stub or test sequencer) and the ALU datapath.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 50 +++++
 rtl/alu_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, datapath widths and sequencer state encoding for the ALU
// command sequencer and its FIFO.
package alu_pkg;

    localparam int ALU_DW = 8;
    localparam int ALU_RW = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

    // The only opcode the sequencer interprets: a divide with a zero divisor.
    function automatic logic is_divz(input logic [3:0] sel, input logic [ALU_DW-1:0] b);
        return (sel == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for queued ALU commands; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = wptr_q + PTR_ONE;
        if (pop_i)  rptr_d = rptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues tagged ALU commands, drives them one at a time onto an external
// combinational ALU, and returns captured results in command order.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int                DEPTH      = 4,
    parameter int                TAG_W      = 4,
    parameter logic [ALU_RW-1:0] DIVZ_VALUE = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ALU_DW-1:0] cmd_a,
    input  logic [ALU_DW-1:0] cmd_b,
    input  logic [3:0]        cmd_sel,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [ALU_DW-1:0] alu_a,
    output logic [ALU_DW-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [ALU_RW-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ALU_RW-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_divz,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid-side signals hold stable until then, ready never depends on valid.

    localparam int EW = 2 * ALU_DW + 4 + TAG_W;

    seq_state_e        state_q, state_d;
    logic [ALU_DW-1:0] alu_a_q, alu_a_d;
    logic [ALU_DW-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ALU_RW-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_divz_q, rsp_divz_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]     fifo_wdata, fifo_rdata;
    logic [ALU_DW-1:0] head_a, head_b;
    logic [3:0]        head_sel;
    logic [TAG_W-1:0]  head_tag;

    // cmd_ready comes from registered pointers only, so rsp_ready cannot reach it.
    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_a, cmd_b, cmd_sel, cmd_tag};
    assign {head_a, head_b, head_sel, head_tag} = fifo_rdata;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_divz_d  = rsp_divz_q;
        rsp_tag_d   = rsp_tag_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                rsp_valid_d = 1'b1;
                rsp_tag_d   = tag_q;
                if (is_divz(alu_sel_q, alu_b_q)) begin
                    rsp_data_d  = DIVZ_VALUE;
                    rsp_carry_d = 1'b0;
                    rsp_divz_d  = 1'b1;
                end else begin
                    rsp_data_d  = alu_out;
                    rsp_carry_d = alu_carry;
                    rsp_divz_d  = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Operands only move on a pop, so they hold through IDLE and RESP.
        if (fifo_pop) begin
            alu_a_d   = head_a;
            alu_b_d   = head_b;
            alu_sel_d = head_sel;
            tag_d     = head_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_divz_q  <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_divz_q  <= rsp_divz_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_divz  = rsp_divz_q;
    assign rsp_tag   = rsp_tag_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: ALU model on the alu_* ports, scoreboard of
// expected responses checked whenever the DUT presents a response.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int EXP_W = 4 + 16 + 1 + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [3:0]  cmd_sel, cmd_tag;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_carry, rsp_divz;
    logic [3:0]  rsp_tag;
    logic        busy;

    logic [EXP_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_hs = -1;
    bit gap_en  = 1'b0;
    bit rand_done;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .cmd_tag   (cmd_tag),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_divz  (rsp_divz),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
    );

    // ALU model: carry is always the carry-out of the 8-bit add.
    function automatic logic [16:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] sel);
        logic [15:0] ea, eb, r;
        logic [15:0] rot;
        ea  = {8'h00, a};
        eb  = {8'h00, b};
        rot = {a, a};
        case (sel)
            OP_ADD:  r = ea + eb;
            OP_SUB:  r = ea - eb;
            OP_MUL:  r = ea * eb;
            OP_DIV:  r = (b == 8'h00) ? 16'h0000 : ea / eb;
            OP_SHL:  r = ea << b[2:0];
            OP_SHR:  r = ea >> b[2:0];
            OP_ROL:  r = {8'h00, rot[15 - b[2:0] -: 8]};
            OP_ROR:  r = {8'h00, rot[7 + b[2:0] -: 8]};
            OP_AND:  r = {8'h00, a & b};
            OP_OR:   r = {8'h00, a | b};
            OP_XOR:  r = {8'h00, a ^ b};
            OP_NOR:  r = {8'h00, ~(a | b)};
            OP_NAND: r = {8'h00, ~(a & b)};
            OP_XNOR: r = {8'h00, ~(a ^ b)};
            OP_GT:   r = {15'h0000, a > b};
            default: r = {15'h0000, a == b};
        endcase
        return {ea[8:0] + eb[8:0] > 9'h0FF ? 1'b1 : 1'b0, r};
    endfunction

    always_comb {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);

    function automatic logic [EXP_W-1:0] exp_for(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [3:0] sel, input logic [3:0] tag);
        logic [16:0] m;
        m = alu_model(a, b, sel);
        if (sel == OP_DIV && b == 8'h00) return {tag, 16'hFFFF, 1'b0, 1'b1};
        return {tag, m[15:0], m[16], 1'b0};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Drive one command and hold it until accepted; expectation queued on acceptance.
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                            input logic [3:0] tag, input logic [EXP_W-1:0] exp_word);
        int  waited;
        logic acc;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag;
        cmd_valid = 1'b1;
        waited = 0;
        acc = 1'b0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            waited++;
        end
        #1;
        cmd_valid = 1'b0;
        if (acc) exp_q.push_back(exp_word);
        else check_eq("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_done", {31'd0, n < 400}, 32'd1);
    endtask

    // Scoreboard monitor: every presented response must match the queue head,
    // which also proves rsp_* stay stable across stalled cycles.
    always @(negedge clk) begin
        logic [EXP_W-1:0] h;
        cyc++;
        if (!rst && rsp_valid) begin
            check_eq("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                check_eq("rsp_tag",   {28'd0, rsp_tag},   {28'd0, h[21:18]});
                check_eq("rsp_data",  {16'd0, rsp_data},  {16'd0, h[17:2]});
                check_eq("rsp_carry", {31'd0, rsp_carry}, {31'd0, h[1]});
                check_eq("rsp_divz",  {31'd0, rsp_divz},  {31'd0, h[0]});
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    if (gap_en) begin
                        if (last_hs >= 0) check_eq("rsp_gap", cyc - last_hs, 32'd2);
                        last_hs = cyc;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check_eq({pfx, "_busy"},      {31'd0, busy},      32'd0);
        check_eq({pfx, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({pfx, "_rsp_data"},  {16'd0, rsp_data},  32'd0);
        check_eq({pfx, "_rsp_carry"}, {31'd0, rsp_carry}, 32'd0);
        check_eq({pfx, "_rsp_divz"},  {31'd0, rsp_divz},  32'd0);
        check_eq({pfx, "_rsp_tag"},   {28'd0, rsp_tag},   32'd0);
        check_eq({pfx, "_alu_a"},     {24'd0, alu_a},     32'd0);
        check_eq({pfx, "_alu_b"},     {24'd0, alu_b},     32'd0);
        check_eq({pfx, "_alu_sel"},   {28'd0, alu_sel},   32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rs;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // First add, with latency checked edge by edge
        push_cmd(8'd200, 8'd100, OP_ADD, 4'd3, {4'd3, 16'd300, 1'b1, 1'b0});
        check_eq("lat_n0", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("lat_n1", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("lat_n2", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        wait_drain();

        // Multiply and divide cases
        push_cmd(8'hFF, 8'hFF, OP_MUL, 4'd1, {4'd1, 16'hFE01, 1'b1, 1'b0});
        push_cmd(8'd9, 8'd0, OP_DIV, 4'd2, {4'd2, 16'hFFFF, 1'b0, 1'b1});
        push_cmd(8'd9, 8'd2, OP_DIV, 4'd4, {4'd4, 16'd4, 1'b0, 1'b0});
        wait_drain();

        // Backpressure: 5 accepted, sixth held off until a pop frees space
        rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++)
            push_cmd(8'(t * 17 + 5), 8'(t + 3), 4'(t), 4'(t),
                     exp_for(8'(t * 17 + 5), 8'(t + 3), 4'(t), 4'(t)));
        cmd_a = 8'd90; cmd_b = 8'd8; cmd_sel = 4'd5; cmd_tag = 4'd5;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check_eq("full_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        gap_en = 1'b1;
        last_hs = -1;
        rsp_ready = 1'b1;
        push_cmd(8'd90, 8'd8, 4'd5, 4'd5, exp_for(8'd90, 8'd8, 4'd5, 4'd5));
        wait_drain();
        check_eq("bp_all_seen", {31'd0, last_hs >= 0}, 32'd1);
        gap_en = 1'b0;

        // Reset while a response is pending and two commands are queued
        rsp_ready = 1'b0;
        push_cmd(8'd1, 8'd2, OP_ADD, 4'd7, exp_for(8'd1, 8'd2, OP_ADD, 4'd7));
        push_cmd(8'd3, 8'd4, OP_SUB, 4'd8, exp_for(8'd3, 8'd4, OP_SUB, 4'd8));
        push_cmd(8'd5, 8'd6, OP_XOR, 4'd9, exp_for(8'd5, 8'd6, OP_XOR, 4'd9));
        check_eq("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_eq("post_rst_idle", {31'd0, busy}, 32'd0);
        push_cmd(8'd12, 8'd3, OP_AND, 4'd6, exp_for(8'd12, 8'd3, OP_AND, 4'd6));
        wait_drain();

        // Random commands against a randomly stalling consumer
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    ra = 8'($urandom_range(0, 255));
                    rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                    rs = 4'($urandom_range(0, 15));
                    push_cmd(ra, rb, rs, 4'(i), exp_for(ra, rb, rs, 4'(i)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
